// File: rtl/midi_uart_tx_pkg.sv
// Shared MIDI definitions for the transmit framer (and the receive-side framer):
// status-nibble constants, framer FSM encoding, event payload struct and the
// data-byte-count decode for a status byte.
package midi_uart_tx_pkg;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_POLY_AT  = 4'hA;
  localparam logic [3:0] NIB_CC       = 4'hB;
  localparam logic [3:0] NIB_PROG     = 4'hC;
  localparam logic [3:0] NIB_CHAN_AT  = 4'hD;
  localparam logic [3:0] NIB_PITCH    = 4'hE;
  localparam logic [3:0] NIB_SYS      = 4'hF;

  // State names the byte currently on the wire.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_STATUS = 2'd1,
    SEND_P1     = 2'd2,
    SEND_P2     = 2'd3
  } frame_state_e;

  // Data bytes latched at acceptance; the status byte goes straight to the UART.
  typedef struct packed {
    logic [6:0] p1;
    logic [6:0] p2;
  } midi_params_t;

  // Number of data bytes that follow a status byte (0..2).
  function automatic logic [1:0] midi_data_byte_count(input logic [7:0] cmd);
    logic [1:0] n;
    n = 2'd0;
    case (cmd[7:4])
      NIB_NOTE_OFF, NIB_NOTE_ON, NIB_POLY_AT, NIB_CC, NIB_PITCH: n = 2'd2;
      NIB_PROG, NIB_CHAN_AT:                                   n = 2'd1;
      NIB_SYS: begin
        case (cmd[3:0])
          4'h1, 4'h3: n = 2'd1;
          4'h2:       n = 2'd2;
          default:    n = 2'd0;
        endcase
      end
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Channel-voice status (80..EF): the only bytes eligible for running status.
  function automatic logic is_chan_voice(input logic [7:0] cmd);
    return cmd[7] && (cmd[7:4] != NIB_SYS);
  endfunction

endpackage

// File: rtl/midi_uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each held
// CLK_DIVISOR cycles. byte_ready is also high in the last cycle of the stop
// bit so the next byte can follow with no idle gap.
module uart_tx_byte #(
  parameter int CLK_DIVISOR = 512,
  parameter int CNT_BITS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       serial_tx,
  output logic       busy
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CLK_DIVISOR - 1);

  logic [CNT_BITS-1:0] cnt;
  logic [3:0]          bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]          shreg;     // remaining data bits plus stop bit, LSB next
  logic                bit_end;

  assign bit_end    = (cnt == CNT_LAST);
  assign byte_ready = !busy || (bit_end && (bit_idx == 4'd9));

  // Bit timing and shifting; serial_tx is a flop so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      serial_tx <= 1'b1;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      shreg     <= '1;
    end else if (byte_valid && byte_ready) begin
      busy      <= 1'b1;
      serial_tx <= 1'b0;
      cnt       <= '0;
      bit_idx   <= 4'd0;
      shreg     <= {1'b1, byte_data};
    end else if (busy) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy      <= 1'b0;
          serial_tx <= 1'b1;
        end else begin
          bit_idx   <= bit_idx + 4'd1;
          serial_tx <= shreg[0];
          shreg     <= {1'b1, shreg[8:1]};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI event transmitter: accepts one event per valid/ready handshake and
// sends status + 0..2 data bytes back-to-back on a 31250-baud 8N1 line.
// Optional MIDI_RUNNING_STATUS_EN suppresses a repeated channel-voice status.
module midi_uart_tx
  import midi_uart_tx_pkg::*;
#(
  parameter int CLK_DIVISOR = 512,
  parameter int CNT_BITS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_event_valid,
  output logic       midi_event_ready,
  input  logic [7:0] midi_command,
  input  logic [6:0] midi_parameter_1,
  input  logic [6:0] midi_parameter_2,
  output logic       serial_tx,
  output logic       busy
);

  frame_state_e state_q, state_d;
  midi_params_t par_q;
  logic [1:0]   nb_q;
  logic         ready_d;
  logic         accept;
  logic         suppress;
  logic         byte_valid, byte_ready;
  logic [7:0]   byte_data;

  assign accept = midi_event_valid && midi_event_ready;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] rs_q;
  logic       rs_vld_q;

  assign suppress = rs_vld_q && is_chan_voice(midi_command) && (midi_command == rs_q);

  // Running-status cache: follows channel-voice status, dropped by system common/exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q     <= 8'h00;
      rs_vld_q <= 1'b0;
    end else if (accept && is_chan_voice(midi_command)) begin
      rs_q     <= midi_command;
      rs_vld_q <= 1'b1;
    end else if (accept && (midi_command[7:3] == 5'b11110)) begin
      rs_vld_q <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Framer state, handshake flop and event capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      midi_event_ready <= 1'b1;
      par_q            <= '0;
      nb_q             <= 2'd0;
    end else begin
      state_q          <= state_d;
      midi_event_ready <= ready_d;
      if (accept) begin
        par_q <= '{p1: midi_parameter_1, p2: midi_parameter_2};
        nb_q  <= midi_data_byte_count(midi_command);
      end
    end
  end

  // Next byte selection: hand the serialiser its next byte on the edge the
  // current one ends, so frames leave the line without gaps.
  always_comb begin
    state_d    = state_q;
    ready_d    = midi_event_ready;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state_q)
      IDLE: begin
        // Commands without bit 7 are swallowed here: ready never drops.
        if (accept && midi_command[7]) begin
          byte_valid = 1'b1;
          ready_d    = 1'b0;
          if (suppress) begin
            byte_data = {1'b0, midi_parameter_1};
            state_d   = SEND_P1;
          end else begin
            byte_data = midi_command;
            state_d   = SEND_STATUS;
          end
        end
      end
      SEND_STATUS: begin
        if (byte_ready) begin
          if (nb_q != 2'd0) begin
            byte_valid = 1'b1;
            byte_data  = {1'b0, par_q.p1};
            state_d    = SEND_P1;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      SEND_P1: begin
        if (byte_ready) begin
          if (nb_q == 2'd2) begin
            byte_valid = 1'b1;
            byte_data  = {1'b0, par_q.p2};
            state_d    = SEND_P2;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      SEND_P2: begin
        if (byte_ready) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLK_DIVISOR (CLK_DIVISOR),
    .CNT_BITS    (CNT_BITS)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .serial_tx  (serial_tx),
    .busy       (busy)
  );

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx with CLK_DIVISOR=4: a line decoder collects
// bytes and their start cycles; each event is checked for bytes, spacing,
// latency, busy length and ready return.
module tb_midi_uart_tx;

  localparam int DIV      = 4;
  localparam int BYTE_CYC = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       midi_event_valid = 1'b0;
  logic       midi_event_ready;
  logic [7:0] midi_command = 8'h00;
  logic [6:0] midi_parameter_1 = 7'h00;
  logic [6:0] midi_parameter_2 = 7'h00;
  logic       serial_tx;
  logic       busy;

  always #5 clk = ~clk;

  midi_uart_tx #(.CLK_DIVISOR(DIV), .CNT_BITS(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .midi_event_valid (midi_event_valid),
    .midi_event_ready (midi_event_ready),
    .midi_command     (midi_command),
    .midi_parameter_1 (midi_parameter_1),
    .midi_parameter_2 (midi_parameter_2),
    .serial_tx        (serial_tx),
    .busy             (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, busy_total = 0, low_total = 0;
  int acc_n = 0, rdy_n = 0;

  logic [7:0] rxq[$];
  int         rxt[$];
  logic       rxs[$];

  // free-running counters, sampled before the edge updates the DUT
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy === 1'b1)      busy_total <= busy_total + 1;
    if (serial_tx === 1'b0) low_total  <= low_total + 1;
  end

  // line decoder: detects a start bit, samples each bit at its first cycle
  logic [7:0] dbyte;
  logic       dstop;
  bit         dab;
  int         dt0;
  always begin
    @(negedge clk);
    if (!rst && serial_tx === 1'b0) begin
      dt0 = cyc; dab = 1'b0; dbyte = 8'h00; dstop = 1'b0;
      for (int k = 1; k < BYTE_CYC; k++) begin
        @(negedge clk);
        if (rst) begin dab = 1'b1; break; end
        if (k % DIV == 0 && k / DIV <= 8) dbyte[k/DIV-1] = serial_tx;
        else if (k == 9 * DIV)            dstop = serial_tx;
      end
      if (!dab) begin
        rxq.push_back(dbyte);
        rxt.push_back(dt0);
        rxs.push_back(dstop);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // call at a negedge; returns at the negedge after acceptance with inputs scrambled
  task automatic send_ev(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    int i;
    midi_command = c; midi_parameter_1 = a; midi_parameter_2 = b;
    midi_event_valid = 1'b1;
    i = 0;
    while (!midi_event_ready && i < 2000) begin @(negedge clk); i++; end
    if (!midi_event_ready) chk("accept_timeout", 0, 1);
    acc_n = cyc;
    @(negedge clk);
    midi_event_valid = 1'b0;
    midi_command = 8'hE7; midi_parameter_1 = 7'h55; midi_parameter_2 = 7'h2A;
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!midi_event_ready && i < 2000) begin @(negedge clk); i++; end
    if (!midi_event_ready) chk("ready_timeout", 0, 1);
    rdy_n = cyc;
  endtask

  task automatic chk_frame(input string tag, input int base, input int n, input logic [47:0] exp);
    chk({tag, "_nbytes"}, rxq.size() - base, n);
    if (rxq.size() > base) chk({tag, "_latency"}, rxt[base] - acc_n, 1);
    for (int i = 0; i < n && base + i < rxq.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), rxq[base+i], exp[8*(n-1-i) +: 8]);
      chk($sformatf("%s_stop%0d", tag, i), rxs[base+i], 1);
      chk($sformatf("%s_gap%0d", tag, i), rxt[base+i] - rxt[base], i * BYTE_CYC);
    end
  endtask

  task automatic do_event(input string tag, input logic [7:0] c, input logic [6:0] a,
                          input logic [6:0] b, input int n, input logic [47:0] exp);
    int base, b0;
    base = rxq.size();
    b0   = busy_total;
    send_ev(c, a, b);
    wait_ready();
    chk_frame(tag, base, n, exp);
    chk({tag, "_busy"}, busy_total - b0, n * BYTE_CYC);
    chk({tag, "_ready_at"}, rdy_n - acc_n, n * BYTE_CYC + 1);
  endtask

  initial begin
    int base, b0, l0, a1;

    repeat (3) @(negedge clk);
    chk("rst_tx", serial_tx, 1);
    chk("rst_ready", midi_event_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    do_event("note_on", 8'h90, 7'h3C, 7'h64, 3, 48'h903C64);
    do_event("prog",    8'hC5, 7'h07, 7'h7F, 2, 48'hC507);
    do_event("rt_clk",  8'hF8, 7'h00, 7'h00, 1, 48'hF8);

    // back-to-back: valid held, second accept on the cycle ready rises
    base = rxq.size();
    midi_command = 8'hF8; midi_event_valid = 1'b1;
    wait_ready();
    a1 = cyc;
    @(negedge clk);
    chk("b2b_ready_drop", midi_event_ready, 0);
    wait_ready();
    chk("b2b_accept_at", cyc - a1, BYTE_CYC + 1);
    @(negedge clk);
    midi_event_valid = 1'b0;
    wait_ready();
    chk("b2b_nbytes", rxq.size() - base, 2);
    if (rxq.size() >= base + 2) begin
      chk("b2b_byte0", rxq[base], 8'hF8);
      chk("b2b_byte1", rxq[base+1], 8'hF8);
      chk("b2b_start0", rxt[base] - a1, 1);
      chk("b2b_start1", rxt[base+1] - rxt[base], BYTE_CYC + 1);
    end

    // running status sequence
    do_event("rs_first", 8'h90, 7'h3C, 7'h64, 3, 48'h903C64);
`ifdef MIDI_RUNNING_STATUS_EN
    do_event("rs_second", 8'h90, 7'h40, 7'h64, 2, 48'h4064);
    do_event("rs_rt",     8'hF8, 7'h00, 7'h00, 1, 48'hF8);
    do_event("rs_third",  8'h90, 7'h41, 7'h64, 2, 48'h4164);
`else
    do_event("rs_second", 8'h90, 7'h40, 7'h64, 3, 48'h904064);
    do_event("rs_rt",     8'hF8, 7'h00, 7'h00, 1, 48'hF8);
    do_event("rs_third",  8'h90, 7'h41, 7'h64, 3, 48'h904164);
`endif
    do_event("rs_f1",     8'hF1, 7'h00, 7'h33, 2, 48'hF100);
    do_event("rs_resend", 8'h90, 7'h42, 7'h64, 3, 48'h904264);

    // invalid command: swallowed silently
    base = rxq.size(); b0 = busy_total; l0 = low_total;
    send_ev(8'h3C, 7'h00, 7'h00);
    chk("inv_ready", midi_event_ready, 1);
    chk("inv_busy", busy, 0);
    repeat (50) @(negedge clk);
    chk("inv_line_low", low_total - l0, 0);
    chk("inv_busy_cyc", busy_total - b0, 0);
    chk("inv_nbytes", rxq.size() - base, 0);

    // reset during the second data bit of a note-on
    base = rxq.size();
    send_ev(8'h90, 7'h3C, 7'h64);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_tx", serial_tx, 1);
    chk("mrst_ready", midi_event_ready, 1);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    b0 = busy_total; l0 = low_total;
    repeat (60) @(negedge clk);
    chk("mrst_line_low", low_total - l0, 0);
    chk("mrst_busy_cyc", busy_total - b0, 0);
    chk("mrst_nbytes", rxq.size() - base, 0);
    do_event("post_rst_cc", 8'hB0, 7'h01, 7'h40, 3, 48'hB00140);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
